// File: rtl/autoinstparam_unpack.sv
// Width-down converter: takes one BITSA-wide word per handshake and replays it
// as BITSA/BITSB narrow beats, least significant beat first.
`timescale 1ns/1ps

module autoinstparam_unpack #(
  parameter int BITSA = 8,
  parameter int BITSB = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITSA-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITSB-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  // state | meaning
  // IDLE  | no word held, input side open
  // SHIFT | word held, presenting beat cnt_q from the low end of hold_q

  localparam int BEATS = BITSA / BITSB;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  generate
    if (BITSA % BITSB != 0) begin : g_bad_ratio
      $error("autoinstparam_unpack: BITSA must be a multiple of BITSB");
    end
    if (BEATS < 1 || BEATS > 256) begin : g_bad_beats
      $error("autoinstparam_unpack: BITSA/BITSB must be within 1..256");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [BITSA-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state_q == SHIFT);
  assign out_last  = out_valid && (cnt_q == LAST_CNT);
  assign out_data  = hold_q[BITSB-1:0];
  assign busy      = out_valid;
  // Ready only depends on registered state and out_ready, never on in_valid.
  assign in_ready  = !out_valid || (out_ready && out_last);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          hold_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_fire) begin
          if (!out_last) begin
            hold_d = hold_q >> BITSB;
            cnt_d  = cnt_q + CW'(1);
          end else if (in_fire) begin
            hold_d = in_data;
            cnt_d  = '0;
          end else begin
            // Clearing the holding register keeps out_data at zero while idle.
            hold_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
